// File: rtl/quan_mac_drain.sv
// Drain and requantization stage on the read side of the packed DSP MAC.
// Captures the final packed accumulator word, splits it into signed lanes by
// packing mode, rounds/shifts/saturates each lane, and streams the lanes out
// one per beat. A one-cycle acc_clr is returned to the MAC on every capture.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a final accumulator word (in_ready high)
// EMIT  | streaming lanes of the captured word, r_cnt = current lane
module quan_mac_drain #(
    parameter int PIX88_W = 24,
    parameter int PIX18_W = 16,
    parameter int ACC_W   = 64,
    parameter int OUT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_acc,
    input  logic [3:0]       in_mode,
    input  logic [4:0]       in_shift,
    output logic             acc_clr,
    output logic             bad_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_lane,
    output logic             out_last
);

    // One guard bit above the widest lane so the rounding add cannot overflow.
    localparam int VW = PIX88_W + 1;
    localparam logic [4:0] SHIFT_MAX = 5'(PIX88_W - 1);
    localparam logic signed [VW-1:0] SAT_MAX = VW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [VW-1:0] SAT_MIN = -SAT_MAX - VW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [3:0]         r_mode;
    logic [4:0]         r_shift;
    logic [1:0]         r_cnt;
    logic               r_rdy;
    logic               r_clr;
    logic               r_bad;

    logic signed [PIX88_W-1:0] w_l88;
    logic signed [PIX18_W-1:0] w_l18;
    logic signed [VW-1:0]      w_v;
    logic        [VW-1:0]      w_rnd;
    logic signed [VW-1:0]      w_r;
    logic        [OUT_W-1:0]   w_sat;
    logic        [1:0]         w_last_idx;
    logic                      w_is_last;

    // Lane selection and sign extension to the common working width.
    always_comb begin
        w_l88 = r_acc[int'(r_cnt[0]) * PIX88_W +: PIX88_W];
        w_l18 = r_acc[int'(r_cnt) * PIX18_W +: PIX18_W];
        if (r_mode == 4'd0) begin
            w_v = VW'(w_l88);
        end else begin
            w_v = VW'(w_l18);
        end
    end

    // Round half up, arithmetic shift, then clamp to the signed output range.
    always_comb begin
        w_rnd = '0;
        if (r_shift != 5'd0) begin
            w_rnd = VW'(1) << (r_shift - 5'd1);
        end
        w_r = (w_v + $signed(w_rnd)) >>> r_shift;
        if (w_r > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_W-1:0];
        end else if (w_r < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_W-1:0];
        end else begin
            w_sat = w_r[OUT_W-1:0];
        end
    end

    assign w_last_idx = (r_mode == 4'd0) ? 2'd1 : 2'd3;
    assign w_is_last  = (r_cnt == w_last_idx);

    assign in_ready  = r_rdy;
    assign acc_clr   = r_clr;
    assign bad_mode  = r_bad;
    assign out_valid = (r_state == EMIT);
    assign out_lane  = r_cnt;
    assign out_last  = (r_state == EMIT) && w_is_last;
    assign out_data  = (r_state == EMIT) ? w_sat : '0;

    // Capture/emit sequencer; in_ready, acc_clr and bad_mode are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_mode  <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
            r_clr   <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_clr <= 1'b0;
            r_bad <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_rdy <= 1'b1;
                    if (in_valid && r_rdy) begin
                        r_acc   <= in_acc;
                        r_mode  <= in_mode;
                        r_shift <= (in_shift > SHIFT_MAX) ? SHIFT_MAX : in_shift;
                        r_cnt   <= 2'd0;
                        r_clr   <= 1'b1;
                        if (in_mode <= 4'd1) begin
                            r_state <= EMIT;
                            r_rdy   <= 1'b0;
                        end else begin
                            // Unsupported packing: drop the word, stay ready.
                            r_bad <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (w_is_last) begin
                            r_state <= IDLE;
                            r_cnt   <= 2'd0;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quan_mac_drain.sv
// Directed testbench for quan_mac_drain: hand-computed vectors per scenario.
module tb_quan_mac_drain;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_acc;
    logic [3:0]  in_mode;
    logic [4:0]  in_shift;
    logic        acc_clr;
    logic        bad_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_lane;
    logic        out_last;

    int errs;
    int checks;

    quan_mac_drain dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_mode   (in_mode),
        .in_shift  (in_shift),
        .acc_clr   (acc_clr),
        .bad_mode  (bad_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, wait (bounded) for in_ready, handshake at edge k,
    // and return at k+1 (+1ns) with in_valid dropped.
    task automatic start_word(input logic [63:0] acc, input logic [3:0] mode,
                              input logic [4:0] shift);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errs++;
            $display("FAIL start_word_timeout in_ready=%0b required=1", in_ready);
        end
        in_acc   = acc;
        in_mode  = mode;
        in_shift = shift;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #23;
        checks++;
        if ({in_ready, acc_clr, bad_mode, out_valid, out_last} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags got=%b required=00000",
                     {in_ready, acc_clr, bad_mode, out_valid, out_last});
        end
        checks++;
        if ({out_data, out_lane} !== 10'd0) begin
            errs++;
            $display("FAIL reset_data got data=%h lane=%0d required 0/0", out_data, out_lane);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_release_ready got=%b required=1", in_ready);
        end
    endtask

    task automatic test_mode0_basic();
        out_ready = 1'b1;
        start_word({16'h0, 24'hFFFFFD, 24'h000005}, 4'd0, 5'd0);
        checks++;
        if ({acc_clr, out_valid, out_data, out_lane, out_last} !== {1'b1, 1'b1, 8'h05, 2'd0, 1'b0}) begin
            errs++;
            $display("FAIL m0_lane0 got clr=%b v=%b d=%h l=%0d last=%b required 1 1 05 0 0",
                     acc_clr, out_valid, out_data, out_lane, out_last);
        end
        tick();
        checks++;
        if ({acc_clr, in_ready, out_valid, out_data, out_lane, out_last} !== {1'b0, 1'b0, 1'b1, 8'hFD, 2'd1, 1'b1}) begin
            errs++;
            $display("FAIL m0_lane1 got clr=%b rdy=%b v=%b d=%h l=%0d last=%b required 0 0 1 fd 1 1",
                     acc_clr, in_ready, out_valid, out_data, out_lane, out_last);
        end
        tick();
        checks++;
        if ({in_ready, out_valid, acc_clr} !== 3'b100) begin
            errs++;
            $display("FAIL m0_ready_back got rdy=%b v=%b clr=%b required 1 0 0",
                     in_ready, out_valid, acc_clr);
        end
    endtask

    task automatic test_mode1_shift();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h02;
        exp_d[1] = 8'hFF;
        exp_d[2] = 8'h01;
        exp_d[3] = 8'h7F;
        out_ready = 1'b1;
        start_word(64'h7FFF_0017_FFE8_0018, 4'd1, 5'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_data, out_lane, out_last} !== {1'b1, exp_d[i], 2'(i), (i == 3)}) begin
                errs++;
                $display("FAIL m1_lane%0d got v=%b d=%h l=%0d last=%b required 1 %h %0d %0b",
                         i, out_valid, out_data, out_lane, out_last, exp_d[i], i, (i == 3));
            end
            tick();
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errs++;
            $display("FAIL m1_ready_back got rdy=%b v=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        start_word(64'hFFFF_0040_8000_0003, 4'd1, 5'd0);
        checks++;
        if ({out_data, out_lane, out_last} !== {8'h03, 2'd0, 1'b0}) begin
            errs++;
            $display("FAIL bp_lane0 got d=%h l=%0d last=%b required 03 0 0", out_data, out_lane, out_last);
        end
        tick();
        checks++;
        if ({out_data, out_lane, out_last} !== {8'h80, 2'd1, 1'b0}) begin
            errs++;
            $display("FAIL bp_lane1 got d=%h l=%0d last=%b required 80 1 0", out_data, out_lane, out_last);
        end
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, out_data, out_lane, out_last} !== {1'b1, 8'h40, 2'd2, 1'b0}) begin
                errs++;
                $display("FAIL bp_hold%0d got v=%b d=%h l=%0d last=%b required 1 40 2 0",
                         i, out_valid, out_data, out_lane, out_last);
            end
            if (i == 2) out_ready = 1'b1;
            tick();
        end
        checks++;
        if ({out_valid, out_data, out_lane, out_last} !== {1'b1, 8'hFF, 2'd3, 1'b1}) begin
            errs++;
            $display("FAIL bp_lane3 got v=%b d=%h l=%0d last=%b required 1 ff 3 1",
                     out_valid, out_data, out_lane, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL bp_done got v=%b required 0", out_valid);
        end
    endtask

    task automatic test_bad_mode();
        out_ready = 1'b1;
        start_word(64'h1234_5678_9ABC_DEF0, 4'd5, 5'd3);
        checks++;
        if ({bad_mode, acc_clr, out_valid, in_ready} !== 4'b1101) begin
            errs++;
            $display("FAIL bad_k1 got bad=%b clr=%b v=%b rdy=%b required 1 1 0 1",
                     bad_mode, acc_clr, out_valid, in_ready);
        end
        tick();
        checks++;
        if ({bad_mode, acc_clr, out_valid, in_ready} !== 4'b0001) begin
            errs++;
            $display("FAIL bad_k2 got bad=%b clr=%b v=%b rdy=%b required 0 0 0 1",
                     bad_mode, acc_clr, out_valid, in_ready);
        end
    endtask

    task automatic test_shift_clamp();
        out_ready = 1'b1;
        start_word({16'h0, 24'h7FFFFF, 24'h800000}, 4'd0, 5'd31);
        checks++;
        if ({out_data, out_lane} !== {8'hFF, 2'd0}) begin
            errs++;
            $display("FAIL clamp_lane0 got d=%h l=%0d required ff 0", out_data, out_lane);
        end
        tick();
        checks++;
        if ({out_data, out_lane, out_last} !== {8'h01, 2'd1, 1'b1}) begin
            errs++;
            $display("FAIL clamp_lane1 got d=%h l=%0d last=%b required 01 1 1", out_data, out_lane, out_last);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int hs;
        hs = 0;
        out_ready = 1'b1;
        in_acc    = {16'h0, 24'h000002, 24'h000001};
        in_mode   = 4'd0;
        in_shift  = 5'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (in_ready) hs++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (hs != 3) begin
            errs++;
            $display("FAIL b2b_words got=%0d required=3", hs);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_emit();
        out_ready = 1'b1;
        start_word(64'h0004_0003_0002_0001, 4'd1, 5'd0);
        tick();
        checks++;
        if (out_lane !== 2'd1) begin
            errs++;
            $display("FAIL rst_pre_lane got=%0d required=1", out_lane);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_lane, out_last, in_ready} !== 13'd0) begin
            errs++;
            $display("FAIL rst_mid_outputs got v=%b d=%h l=%0d last=%b rdy=%b required all 0",
                     out_valid, out_data, out_lane, out_last, in_ready);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        start_word({16'h0, 24'hFFFF00, 24'h000010}, 4'd0, 5'd1);
        checks++;
        if ({out_valid, out_data, out_lane, out_last} !== {1'b1, 8'h08, 2'd0, 1'b0}) begin
            errs++;
            $display("FAIL rst_new_lane0 got v=%b d=%h l=%0d last=%b required 1 08 0 0",
                     out_valid, out_data, out_lane, out_last);
        end
        tick();
        checks++;
        if ({out_valid, out_data, out_lane, out_last} !== {1'b1, 8'h80, 2'd1, 1'b1}) begin
            errs++;
            $display("FAIL rst_new_lane1 got v=%b d=%h l=%0d last=%b required 1 80 1 1",
                     out_valid, out_data, out_lane, out_last);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst_new_extra got v=%b required 0", out_valid);
        end
    endtask

    initial begin
        errs      = 0;
        checks    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_acc    = '0;
        in_mode   = '0;
        in_shift  = '0;
        out_ready = 1'b0;
        test_reset();
        test_mode0_basic();
        test_mode1_shift();
        test_backpressure();
        test_bad_mode();
        test_shift_clamp();
        test_back_to_back();
        test_reset_mid_emit();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/quan_mac_drain.md
# quan_mac_drain

Drain and requantization stage on the read side of the packed DSP MAC. At the end of an accumulation window, it captures the MAC's 64-bit packed accumulator word. It splits the word into signed lanes according to the packing mode, rounds and shifts each lane, and saturates it to OUT_W bits. It emits one lane per beat over a valid/ready stream and pulses a clear back to the MAC so the next window starts from zero.

## Interface
- PIX88_W, 24: lane width in mode 0 (2 lanes).
- PIX18_W, 16: lane width in mode 1 (4 lanes).
- ACC_W, 64: packed accumulator width; must equal 4*PIX18_W and be at least 2*PIX88_W.
- OUT_W, 8: signed width of each emitted lane.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  packed accumulator word is final and presented.
- in_ready  out  1  block can capture a word.
- in_acc  in  ACC_W  packed accumulator word.
- in_mode  in  4  packing mode of in_acc: 0 = 2 lanes of PIX88_W, 1 = 4 lanes of PIX18_W.
- in_shift  in  5  arithmetic right-shift amount applied to every lane of this word.
- acc_clr  out  1  one-cycle clear request to the MAC.
- bad_mode  out  1  one-cycle flag: a word with an unsupported mode was accepted.
- out_valid  out  1  out_data holds a lane.
- out_ready  in  1  consumer takes the lane.
- out_data  out  OUT_W  requantized signed lane.
- out_lane  out  2  lane index of out_data.
- out_last  out  1  out_data is the final lane of the captured word.

## Operation
- There are two states, IDLE and EMIT, with in_ready = (state == IDLE).
- **IDLE:** on in_valid && in_ready, the block registers in_acc, in_mode, and min(in_shift, 23), and asserts acc_clr for the next cycle.
  - If in_mode is 0 or 1, it goes to EMIT with lane counter 0.
  - Otherwise it stays in IDLE, discards the word, emits no lanes, and asserts bad_mode for the next cycle.
- **Lane extraction:**
  - Mode 0: lane0 = acc[23:0], lane1 = acc[47:24]. Bits [63:48] are ignored.
  - Mode 1: lane i = acc[16i+15:16i] for i = 0..3.
  - Each lane is sign-extended to 25 bits as v.
- **Requantization:**
  - If shift is 0, r = v.
  - Otherwise, r = (v + 2^(shift-1)) >>> shift, evaluated at 25 bits so it cannot overflow (round half up).
  - out_data = r clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- **EMIT:**
  - out_valid = 1, out_lane = counter, and out_last = (counter == nlanes-1), where nlanes is 2 in mode 0 and 4 in mode 1.
  - On out_ready, the counter increments. On the last lane with out_ready, the block returns to IDLE.
  - out_data, out_lane, and out_last stay stable while out_valid && !out_ready.
- in_valid is ignored outside IDLE. The upstream source must hold its word until in_ready.

## Timing
- **Reset:** reset_n low asynchronously forces state IDLE and clears the counter and all captured registers. While reset_n is low:
  - in_ready = 0.
  - acc_clr = bad_mode = out_valid = out_last = 0.
  - out_data = 0, out_lane = 0.
- in_ready rises in the first cycle after reset_n deasserts.
- **Reset mid-EMIT:** the word is dropped and no further lanes are emitted.
- **Latency:** a handshake at edge k gives out_valid = 1 with lane 0 in cycle k+1. acc_clr and bad_mode are high for exactly cycle k+1.
- **Throughput with out_ready held high:** one word per 3 cycles in mode 0 and per 5 cycles in mode 1.
  - There is no IDLE bypass, so in_ready rises in the cycle after the last lane's handshake.
- out_data, out_lane, and out_last are combinational from registered state and carry no input-to-output path.
- **acc_clr timing:** the MAC clears on acc_clr before the next accumulate. Products arriving in the acc_clr cycle belong to the new window.

## Test plan
- **Mode 0, shift 0, OUT_W 8:** in_acc lane0 = 0x000005, lane1 = 0xFFFFFD → beats (5, lane 0, last 0) then (-3, lane 1, last 1). acc_clr pulses once at k+1. in_ready returns at k+3.
- **Mode 1, shift 4:** lanes 0x0018, 0xFFE8, 0x0017, 0x7FFF → out_data 2, -1, 1, 127.
  - The fourth lane saturates.
  - -24 rounds to -1 because (-24 + 8) >>> 4 = -1.
- **Backpressure:** mode 1 word with out_ready low for 3 cycles on lane 2 → lane 2 data and index are held unchanged, no lane is skipped, and out_last appears only on lane 3.
- **Bad mode:** in_mode 5 → bad_mode and acc_clr pulse for one cycle, out_valid never rises, and in_ready is high again at k+1.
- **in_shift 31 with mode 0 lane 0x800000:** the shift clamps to 23 and out_data = -1.
- **Reset_n asserted during lane 1 of a mode 1 word:** outputs go to 0 immediately. After release, a fresh mode 0 word emits exactly 2 lanes starting at lane 0.
